// File: rtl/fifo_sync_pkg.sv
// Shared definitions for the fifo_sync block: reset level and width helpers
// used to size the occupancy counter and the wrap-around pointers.
package fifo_sync_pkg;

    localparam logic RESET_ACTIVE = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Counter must represent 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Wrap-around index 0..DEPTH-1 with increment enable and synchronous flush;
// the explicit wrap keeps it correct for non-power-of-two depths.
module fifo_sync_ptr
    import fifo_sync_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (i_flush) begin
            ptr_d = '0;
        end else if (i_inc) begin
            if (ptr_q == PW'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset == RESET_ACTIVE) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock ready/valid FIFO with occupancy count, almost-full/empty flags
// and synchronous flush. Handshake flags are registered, never combinational.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int DEPTH            = 4,
    parameter int CLEAR_ON_EMPTY   = 1,
    parameter int ALMOST_FULL_LVL  = DEPTH - 1,
    parameter int ALMOST_EMPTY_LVL = 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_write_valid,
    input  logic [WIDTH-1:0]         i_write_data,
    output logic                     o_write_ready,
    output logic                     o_read_valid,
    output logic [WIDTH-1:0]         o_read_data,
    input  logic                     i_read_ready,
    output logic [cnt_w(DEPTH)-1:0]  o_count,
    output logic                     o_almost_full,
    output logic                     o_almost_empty
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             rvalid_q;
    logic             wready_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_write;
    logic             do_read;

    // Flush wins: a write or read in the flush cycle has no effect on state.
    assign do_write = i_write_valid && wready_q && !i_flush;
    assign do_read  = rvalid_q && i_read_ready && !i_flush;

    fifo_sync_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_inc   (do_write),
        .o_ptr   (wr_ptr)
    );

    fifo_sync_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_inc   (do_read),
        .o_ptr   (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (i_flush) begin
            count_d = '0;
        end else if (do_write && !do_read) begin
            count_d = count_q + CW'(1);
        end else if (do_read && !do_write) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset == RESET_ACTIVE) begin
            count_q  <= '0;
            rvalid_q <= 1'b0;
            wready_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            rvalid_q <= (count_d != '0);
            wready_q <= (count_d != CW'(DEPTH));
        end
    end

    always_ff @(posedge i_clock) begin
        if (do_write) begin
            mem_q[wr_ptr] <= i_write_data;
        end
    end

    always_comb begin
        o_read_data = mem_q[rd_ptr];
        if ((CLEAR_ON_EMPTY != 0) && !rvalid_q) begin
            o_read_data = '0;
        end
    end

    assign o_write_ready  = wready_q;
    assign o_read_valid   = rvalid_q;
    assign o_count        = count_q;
    assign o_almost_full  = (count_q >= CW'(ALMOST_FULL_LVL));
    assign o_almost_empty = (count_q <= CW'(ALMOST_EMPTY_LVL));

endmodule
